// File: rtl/xor_cipher_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// xor_cipher_pkg: widths and state encoding shared by the XOR cipher path
// Rev 1.0
//------------------------------------------------------------------
package xor_cipher_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int BANK_W = 2;

  localparam logic [BANK_W-1:0] KEY_BANK_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/key_index_ctr.sv
`default_nettype none
//------------------------------------------------------------------
// key_index_ctr: key-ROM index counter wrapping at KEY_LEN, clear has priority
// Rev 1.0
//------------------------------------------------------------------
module key_index_ctr
  import xor_cipher_pkg::*;
#(
  parameter int KEY_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] idx
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(KEY_LEN - 1);

  logic [ADDR_W-1:0] r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (inc) begin
      r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
    end
  end

  assign idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/xor_stream_engine.sv
`default_nettype none
//------------------------------------------------------------------
// xor_stream_engine: byte-stream XOR encrypt/decrypt against a banked key ROM
// Rev 1.0
//------------------------------------------------------------------
module xor_stream_engine
  import xor_cipher_pkg::*;
#(
  parameter int KEY_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BANK_W-1:0] key_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [BANK_W-1:0] key_bank,
  output logic [ADDR_W-1:0] key_a,
  input  logic [DATA_W-1:0] key_d,
  output logic              err_key,
  output logic              busy
);

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic [BANK_W-1:0]   r_bank;
  logic                r_frame_start;
  logic                r_err;
  logic                w_accept, w_bad_start, w_emit_done, w_drain_end, w_inc, w_clr;
  logic [ADDR_W-1:0]   w_idx;

  assign w_accept    = in_ready && in_valid;
  assign w_bad_start = r_frame_start && (key_sel == KEY_BANK_INVALID);
  assign w_emit_done = (r_state == ST_EMIT) && out_ready;
  assign w_drain_end = (r_state == ST_DRAIN) && w_accept && in_last;
  assign w_inc       = w_emit_done && !r_last;
  assign w_clr       = (w_emit_done && r_last) || w_drain_end;

  key_index_ctr #(
    .KEY_LEN (KEY_LEN)
  ) u_key_index_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .clr   (w_clr),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_data        <= '0;
      r_last        <= 1'b0;
      r_bank        <= '0;
      r_frame_start <= 1'b1;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_IDLE) && w_accept && w_bad_start;
      if ((r_state == ST_IDLE) && w_accept) begin
        r_data <= in_data;
        r_last <= in_last;
        if (r_frame_start) r_bank <= key_sel;
      end
      if (w_emit_done)      r_frame_start <= r_last;
      else if (w_drain_end) r_frame_start <= 1'b1;
    end
  end

  // Address and bank stay put while EMIT waits, so key_d and the XOR hold too
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          if (w_bad_start) w_next = in_last ? ST_IDLE : ST_DRAIN;
          else             w_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: w_next = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        out_data  = r_data ^ key_d;
        out_last  = r_last;
        if (out_ready) w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        in_ready = !reset;
        if (in_valid && in_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign key_bank = r_bank;
  assign key_a    = w_idx;
  assign err_key  = r_err;
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
